// File: rtl/runlen_detect_ctrl_pkg.sv
// Shared types and default widths for the run-length detector controller.
package runlen_ctrl_pkg;

  localparam int unsigned DEF_RUN_W = 4;
  localparam int unsigned DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/runlen_detect_ctrl_if.sv
// Configuration handshake bundle between the host and the detector controller.
interface runlen_detect_ctrl_if
  import runlen_ctrl_pkg::*;
#(
  parameter int unsigned RUN_W = DEF_RUN_W,
  parameter int unsigned CNT_W = DEF_CNT_W
);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [RUN_W-1:0] cfg_len;
  logic [CNT_W-1:0] cfg_limit;
  logic             cfg_overlap;

  modport master (
    output cfg_valid,
    output cfg_len,
    output cfg_limit,
    output cfg_overlap,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_len,
    input  cfg_limit,
    input  cfg_overlap,
    output cfg_ready
  );

endinterface

// File: rtl/runlen_detect_ctrl_run_counter.sv
// Saturating run-length counter; flags a match on the edge that completes a run.
module run_counter
  import runlen_ctrl_pkg::*;
#(
  parameter int unsigned RUN_W = DEF_RUN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic             x_i,
  input  logic [RUN_W-1:0] len_i,
  input  logic             overlap_i,
  output logic             match_o,
  output logic [RUN_W-1:0] run_d_o
);

  localparam logic [RUN_W-1:0] RunMax = '1;

  logic [RUN_W-1:0] run_q, run_d, run_inc;

  // Next run count and same-edge match strobe
  always_comb begin
    run_inc = (run_q == RunMax) ? run_q : run_q + 1'b1;
    match_o = 1'b0;
    run_d   = run_q;
    if (clear_i) begin
      run_d = '0;
    end else if (en_i) begin
      if (!x_i) begin
        run_d = '0;
      end else begin
        match_o = overlap_i ? (run_inc >= len_i) : (run_inc == len_i);
        // Non-overlap restarts the run; overlap keeps counting (saturating)
        run_d   = (match_o && !overlap_i) ? '0 : run_inc;
      end
    end
  end

  // Run count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= '0;
    end else begin
      run_q <= run_d;
    end
  end

  assign run_d_o = run_d;

endmodule

// File: rtl/runlen_detect_ctrl.sv
// Programmable run-length detector: config handshake, match pulses, match limit.
module runlen_detect_ctrl
  import runlen_ctrl_pkg::*;
#(
  parameter int unsigned RUN_W = DEF_RUN_W,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  runlen_detect_ctrl_if.slave  cfg,
  input  logic                 abort_i,
  input  logic                 x_i,
  output logic                 match_o,
  output logic [CNT_W-1:0]     match_cnt_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 cfg_err_o
);

  state_e           state_q;
  logic [RUN_W-1:0] len_q;
  logic [CNT_W-1:0] limit_q;
  logic             overlap_q;
  logic [CNT_W-1:0] match_cnt_q;
  logic             match_q;
  logic             cfg_err_q;

  logic             busy;
  logic             cfg_fire;
  logic             run_match;
  logic [RUN_W-1:0] run_d;
  logic [CNT_W-1:0] cnt_inc;
  state_e           run_state;

  assign busy      = (state_q == StArmed) || (state_q == StRun);
  assign cfg_fire  = cfg.cfg_valid && cfg.cfg_ready;
  // Count never exceeds a nonzero limit, so saturation only matters when unlimited
  assign cnt_inc   = (match_cnt_q == '1) ? match_cnt_q : match_cnt_q + 1'b1;
  assign run_state = (run_d == '0) ? StArmed : StRun;

  run_counter #(
    .RUN_W (RUN_W)
  ) u_run_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (abort_i || cfg_fire),
    .en_i      (busy),
    .x_i       (x_i),
    .len_i     (len_q),
    .overlap_i (overlap_q),
    .match_o   (run_match),
    .run_d_o   (run_d)
  );

  // Controller FSM; abort beats the config handshake, which beats x processing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      len_q       <= '0;
      limit_q     <= '0;
      overlap_q   <= 1'b0;
      match_cnt_q <= '0;
      match_q     <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      match_q   <= 1'b0;
      cfg_err_q <= 1'b0;
      if (abort_i) begin
        // A config offered together with abort is dropped
        state_q <= StIdle;
      end else if (cfg_fire) begin
        if (cfg.cfg_len == '0) begin
          cfg_err_q <= 1'b1;
          state_q   <= StIdle;
        end else begin
          len_q       <= cfg.cfg_len;
          limit_q     <= cfg.cfg_limit;
          overlap_q   <= cfg.cfg_overlap;
          match_cnt_q <= '0;
          state_q     <= StArmed;
        end
      end else if (busy) begin
        state_q <= run_state;
        if (run_match) begin
          match_q     <= 1'b1;
          match_cnt_q <= cnt_inc;
          if ((limit_q != '0) && (cnt_inc == limit_q)) begin
            state_q <= StDone;
          end
        end
      end
    end
  end

  assign cfg.cfg_ready = (state_q == StIdle) || (state_q == StDone);
  assign busy_o        = busy;
  assign done_o        = (state_q == StDone);
  assign match_o       = match_q;
  assign match_cnt_o   = match_cnt_q;
  assign cfg_err_o     = cfg_err_q;

endmodule

// File: tb/tb_runlen_detect_ctrl.sv
// Scoreboard bench for runlen_detect_ctrl: stimulus queues expectations, monitor checks.
module tb_runlen_detect_ctrl;
  import runlen_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       abort = 1'b0;
  logic       x = 1'b0;
  logic       match, busy, done, cfg_err;
  logic [7:0] match_cnt;

  runlen_detect_ctrl_if cfg_if ();

  runlen_detect_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg         (cfg_if),
    .abort_i     (abort),
    .x_i         (x),
    .match_o     (match),
    .match_cnt_o (match_cnt),
    .busy_o      (busy),
    .done_o      (done),
    .cfg_err_o   (cfg_err)
  );

  always #5 clk = ~clk;

  // kind 0 = match pulse, 1 = cfg_err pulse
  typedef struct {
    int         cyc;
    bit         kind;
    logic [7:0] cnt;
    bit         done;
  } ev_t;

  typedef struct {
    int         cyc;
    bit         busy;
    bit         done;
    bit         ready;
    logic [7:0] cnt;
  } st_t;

  ev_t ev_q[$];
  st_t st_q[$];
  ev_t e;
  st_t s;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  bit fin = 1'b0;
  bit fin_done = 1'b0;
  bit rst_chk_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: reset values on reset assertion, pulses and status on each falling edge
  always begin
    @(negedge clk or negedge rst_n);
    if (!rst_n) begin
      if (!rst_chk_done) begin
        #1;
        chk("rst_match", {31'd0, match}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_cfg_err", {31'd0, cfg_err}, 0);
        chk("rst_match_cnt", {24'd0, match_cnt}, 0);
        chk("rst_cfg_ready", {31'd0, cfg_if.cfg_ready}, 1);
        rst_chk_done = 1'b1;
      end
    end else begin
      rst_chk_done = 1'b0;
      while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
        chk("pulse_seen", 0, 1);
        void'(ev_q.pop_front());
      end
      if (match || cfg_err) begin
        if (ev_q.size() == 0) begin
          chk("unexpected_pulse", {30'd0, match, cfg_err}, 0);
        end else begin
          e = ev_q.pop_front();
          chk("pulse_cycle", cyc, e.cyc);
          chk("pulse_is_match", {31'd0, match}, {31'd0, !e.kind});
          chk("pulse_is_cfg_err", {31'd0, cfg_err}, {31'd0, e.kind});
          if (!e.kind) chk("match_cnt_at_pulse", {24'd0, match_cnt}, {24'd0, e.cnt});
          chk("done_at_pulse", {31'd0, done}, {31'd0, e.done});
        end
      end
      if (st_q.size() > 0 && st_q[0].cyc == cyc) begin
        s = st_q.pop_front();
        chk("busy", {31'd0, busy}, {31'd0, s.busy});
        chk("done", {31'd0, done}, {31'd0, s.done});
        chk("cfg_ready", {31'd0, cfg_if.cfg_ready}, {31'd0, s.ready});
        chk("match_cnt", {24'd0, match_cnt}, {24'd0, s.cnt});
      end
      if (fin && !fin_done) begin
        chk("leftover_pulses", ev_q.size(), 0);
        chk("leftover_status", st_q.size(), 0);
        fin_done = 1'b1;
      end
    end
  end

  // One cycle of stimulus plus the expectations for the edge it feeds
  task automatic drive(input bit v, input logic [3:0] len, input logic [7:0] lim, input bit ov,
                       input bit xv, input bit ab, input bit em, input bit ee,
                       input logic [7:0] cnt, input bit b, input bit d, input bit r);
    cfg_if.cfg_valid   = v;
    cfg_if.cfg_len     = len;
    cfg_if.cfg_limit   = lim;
    cfg_if.cfg_overlap = ov;
    x                  = xv;
    abort              = ab;
    if (em) ev_q.push_back('{cyc + 1, 1'b0, cnt, d});
    if (ee) ev_q.push_back('{cyc + 1, 1'b1, cnt, d});
    st_q.push_back('{cyc + 1, b, d, r, cnt});
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    abort            = 1'b0;
  endtask

  task automatic xbit(input bit xv, input bit em, input logic [7:0] cnt,
                      input bit b, input bit d, input bit r);
    drive(1'b0, 4'd0, 8'd0, 1'b0, xv, 1'b0, em, 1'b0, cnt, b, d, r);
  endtask

  task automatic send_cfg(input logic [3:0] len, input logic [7:0] lim, input bit ov,
                          input bit ee, input logic [7:0] cnt, input bit b, input bit r);
    drive(1'b1, len, lim, ov, 1'b0, 1'b0, 1'b0, ee, cnt, b, 1'b0, r);
  endtask

  task automatic do_abort(input logic [7:0] cnt);
    drive(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, cnt, 1'b0, 1'b0, 1'b1);
  endtask

  // Bit i of bits/mm is the i-th x sample / expected match; limit-free so busy stays high
  task automatic run_seq(input logic [15:0] bits, input logic [15:0] mm, input int n,
                         input logic [7:0] cnt0);
    logic [7:0] c;
    c = cnt0;
    for (int i = 0; i < n; i++) begin
      if (mm[i]) c = c + 8'd1;
      xbit(bits[i], mm[i], c, 1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cfg_if.cfg_valid   = 1'b0;
    cfg_if.cfg_len     = '0;
    cfg_if.cfg_limit   = '0;
    cfg_if.cfg_overlap = 1'b0;
    #1 rst_n = 1'b0;
    #11 rst_n = 1'b1;
    @(negedge clk);

    // len=3, unlimited, non-overlap: matches after 3rd and 6th 1
    send_cfg(4'd3, 8'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    run_seq(16'h003F, 16'h0024, 7, 8'd0);

    // len=2 overlap: x = 0,1,1,1,1,0,1,1 -> matches at 2,3,4,7
    do_abort(8'd2);
    send_cfg(4'd2, 8'd0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0);
    run_seq(16'h00DE, 16'h009C, 8, 8'd0);

    // len=1, limit=3: third match and done together, then x ignored
    do_abort(8'd4);
    send_cfg(4'd1, 8'd3, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    xbit(1'b1, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
    xbit(1'b1, 1'b1, 8'd2, 1'b1, 1'b0, 1'b0);
    xbit(1'b1, 1'b1, 8'd3, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) xbit(1'b1, 1'b0, 8'd3, 1'b0, 1'b1, 1'b1);

    // Abort out of DONE, then an illegal len=0 config in IDLE
    do_abort(8'd3);
    send_cfg(4'd0, 8'd5, 1'b0, 1'b1, 8'd3, 1'b0, 1'b1);
    xbit(1'b0, 1'b0, 8'd3, 1'b0, 1'b0, 1'b1);

    // Config offered while running is ignored; abort with x=1 at run 2 gives no match
    send_cfg(4'd3, 8'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    run_seq(16'h000F, 16'h0004, 4, 8'd0);
    drive(1'b1, 4'd1, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0, 1'b1);

    // Reset asserted while match is high; config is lost afterwards
    send_cfg(4'd1, 8'd0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0);
    xbit(1'b1, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) xbit(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);

    fin = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
